// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and address-width helper for the burst sequencer
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // A depth of 1 or 2 still needs a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry skid FIFO; push is dropped only when full with no pop
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (do_push) begin
            if (wr_idx_q) slot1_d = push_data;
            else          slot0_d = push_data;
            wr_idx_d = ~wr_idx_q;
        end
        if (do_pop) rd_idx_d = ~rd_idx_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = rd_idx_q ? slot1_q : slot0_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - fills an L-word memory from one stream, then drains it in order to another
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int W  = 8,
    parameter int L  = 10,
    parameter int AW = addr_width(L)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          busy,
    output logic          done,
    output logic          mem_wrt_read,
    output logic [AW-1:0] mem_add,
    output logic [W-1:0]  mem_write,
    output logic          mem_enable,
    input  logic [W-1:0]  mem_rdata
);

    // Read pointer and out-count must be able to hold L itself.
    localparam int            CW     = $clog2(L + 1);
    localparam logic [CW-1:0] L_C    = CW'(L);
    localparam logic [CW-1:0] LAST_C = CW'(L - 1);
    localparam logic [AW-1:0] LAST_A = AW'(L - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;
    logic [AW-1:0] mem_add_q, mem_add_d;
    logic [1:0]    fifo_count;
    logic          fifo_push, fifo_pop, issue;
    logic [2:0]    occ;

    assign fifo_pop = m_valid && m_ready;
    // Occupancy once this cycle's pop and in-flight read settle; keeps 1 word/cycle.
    assign occ = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, pending_q};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        pending_d    = 1'b0;
        done_d       = 1'b0;
        s_ready      = 1'b0;
        mem_wrt_read = 1'b0;
        mem_write    = '0;
        mem_add      = mem_add_q;
        fifo_push    = 1'b0;
        issue        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    out_cnt_d = '0;
                end
            end
            FILL: begin
                s_ready      = 1'b1;
                mem_add      = wr_ptr_q;
                mem_write    = s_data;
                mem_wrt_read = s_valid;
                if (s_valid) begin
                    if (wr_ptr_q == LAST_A) state_d = DRAIN;
                    else                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            DRAIN: begin
                fifo_push = pending_q;
                issue     = (rd_ptr_q < L_C) && (occ < 3'd2);
                if (issue) begin
                    mem_add   = rd_ptr_q[AW-1:0];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    pending_d = 1'b1;
                end
                if (fifo_pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST_C) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        mem_add_d = mem_add;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            mem_add_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_cnt_q <= out_cnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            mem_add_q <= mem_add_d;
        end
    end

    skid_fifo2 #(.W(W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (m_data)
    );

    assign m_valid    = (fifo_count != 2'd0);
    assign busy       = (state_q != IDLE);
    assign mem_enable = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - scoreboard bench for mem_burst_ctrl wired to a registered-read memory
module tb_mem_burst_ctrl;

    localparam int W  = 8;
    localparam int L  = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          m_ready = 1'b1;
    logic          s_ready, m_valid, busy, done, mem_wrt_read, mem_enable;
    logic [W-1:0]  m_data, mem_write, mem_rdata;
    logic [AW-1:0] mem_add;
    logic [W-1:0]  mem [L];

    mem_burst_ctrl #(.W(W), .L(L)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done),
        .mem_wrt_read(mem_wrt_read), .mem_add(mem_add), .mem_write(mem_write),
        .mem_enable(mem_enable), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_enable) begin
            if (mem_wrt_read) mem[mem_add] <= mem_write;
            else              mem_rdata    <= mem[mem_add];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int burst_ins, burst_outs, burst_writes, done_cnt;
    int first_valid_cyc, last_in_cyc, last_out_cyc;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_wrt_read", mem_wrt_read, 0);
        chk("rst_mem_add", mem_add, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_enable", mem_enable, 0);
    endtask

    // Downstream ready: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: model says the burst replays accepted input words in acceptance order
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (s_valid && s_ready) begin
                    exp_q.push_back(s_data);
                    burst_ins++;
                    if (burst_ins == L) last_in_cyc = cyc;
                end
                if (mem_enable && mem_wrt_read) begin
                    chk("write_addr", mem_add, burst_writes);
                    burst_writes++;
                end
                if (!busy) chk("idle_quiet", {s_ready, m_valid, mem_wrt_read}, 0);
                if (mem_enable) chk("addr_range", int'(mem_add < L), 1);
                if (busy) chk("fifo_bound", int'(dut.u_fifo.count <= 2), 1);
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                end
                if (m_valid && first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    chk("first_valid_latency", cyc - last_in_cyc, 3);
                end
                if (m_valid && m_ready) begin
                    chk("output_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", m_data, e);
                    end
                    burst_outs++;
                    last_out_cyc = cyc;
                    if (burst_outs == L && rdy_mode == 0)
                        chk("throughput", cyc - first_valid_cyc, L - 1);
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_last", cyc - last_out_cyc, 1);
                    chk("done_outs", burst_outs, L);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    // sv_mode: 0 = s_valid high, 1 = toggling, 2 = random. start_at re-pulses start in FILL.
    task automatic run_burst(input logic [W-1:0] base, input int sv_mode, input int rmode,
                             input bit rnd, input int start_at, input int rst_after);
        int  idx, guard;
        bit  seen;
        rdy_mode = rmode;
        burst_ins = 0; burst_outs = 0; burst_writes = 0; done_cnt = 0;
        first_valid_cyc = -1; last_in_cyc = 0; last_out_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        s_valid = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < L && guard < 400) begin
            @(posedge clk); #1;
            start = (idx == start_at);
            case (sv_mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (guard % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = rnd ? W'($urandom) : base + W'(idx);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            guard++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        start = 1'b0;
        chk("fill_accepted", idx, L);
        if (rst_after > 0) begin
            guard = 0;
            while (burst_outs < rst_after && guard < 200) begin
                @(negedge clk); #1;
                guard++;
            end
            chk("reached_reset_point", int'(burst_outs >= rst_after), 1);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_reset_vals();
            repeat (15) @(negedge clk);
            #1;
            chk("no_done_after_abort", done_cnt, 0);
            chk("idle_after_abort", busy, 0);
        end else begin
            seen = 1'b0;
            guard = 0;
            while (!seen && guard < 300) begin
                @(negedge clk); #1;
                seen = done;
                guard++;
            end
            chk("done_seen", seen, 1);
            chk("write_count", burst_writes, L);
            chk("out_count", burst_outs, L);
            chk("queue_drained", exp_q.size(), 0);
            chk("busy_after_done", busy, 0);
            chk("done_once", done_cnt, 1);
            if (!rnd)
                for (int i = 0; i < L; i++) chk("mem_contents", mem[i], base + W'(i));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // s_valid in IDLE must be ignored
        burst_writes = 0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data = 8'hEE;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_writes", burst_writes, 0);
        s_valid = 1'b0;

        run_burst(8'h10, 0, 0, 1'b0, -1, 0);
        run_burst(8'hA0, 1, 0, 1'b0, -1, 0);
        run_burst(8'h10, 0, 1, 1'b0, -1, 0);
        run_burst(8'h30, 0, 0, 1'b0, -1, 5);
        run_burst(8'h50, 0, 0, 1'b0, -1, 0);
        run_burst(8'h60, 0, 1, 1'b0, 3, 0);
        run_burst(8'hB0, 0, 0, 1'b0, -1, 0);
        run_burst(8'hC0, 0, 0, 1'b0, -1, 0);
        for (int b = 0; b < 6; b++) run_burst(8'h00, 2, 2, 1'b1, -1, 0);
        run_burst(8'h70, 2, 2, 1'b0, -1, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
